// File: rtl/gs232c_raminit_pkg.sv
// gs232c_raminit_pkg: shared state encoding and default table geometry for predictor RAM init
package gs232c_raminit_pkg;
  typedef enum logic [1:0] {
    READY = 2'd0,
    DRAIN = 2'd1,
    INIT  = 2'd2
  } raminit_state_t;
  localparam int RAMINIT_IDX_W = 8;
  localparam int RAMINIT_DEPTH = 256;
endpackage

// File: rtl/gs232c_raminit_ctrl.sv
// gs232c_raminit_ctrl: sequences the predictor table init sweep after reset and on flush
//   clock, reset      : clock, synchronous active-high reset
//   flush_req         : single-cycle predictor flush request
//   pipe_idle         : no predictor read/update in flight
//   raminit_valid     : sweep active, tables write init value at raminit_index
//   raminit_index     : current sweep index (0..DEPTH-1)
//   init_busy         : controller not READY, holds the front end off
//   init_done         : sticky, first sweep since reset has completed
//   flush_ack         : one-cycle pulse when the flush sweep completes
//   GS232C_RAMINIT_SKIP_EN : when defined, reset lands directly in READY (preloaded RAMs)
module gs232c_raminit_ctrl
  import gs232c_raminit_pkg::*;
#(
  parameter int IDX_W = RAMINIT_IDX_W,
  parameter int DEPTH = RAMINIT_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_req,
  input  logic             pipe_idle,
  output logic             raminit_valid,
  output logic [IDX_W-1:0] raminit_index,
  output logic             init_busy,
  output logic             init_done,
  output logic             flush_ack
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  raminit_state_t state;
  logic pending;
  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef GS232C_RAMINIT_SKIP_EN
      state         <= READY;
      raminit_valid <= 1'b0;
      init_busy     <= 1'b0;
      init_done     <= 1'b1;
`else
      state         <= INIT;
      raminit_valid <= 1'b1;
      init_busy     <= 1'b1;
      init_done     <= 1'b0;
`endif
      raminit_index <= '0;
      flush_ack     <= 1'b0;
      pending       <= 1'b0;
    end else begin
      flush_ack <= 1'b0;
      case (state)
        READY: if (flush_req) begin
          state     <= DRAIN;
          init_busy <= 1'b1;
          pending   <= 1'b1;
        end
        DRAIN: begin
          pending <= pending | flush_req;
          if (pipe_idle) begin
            state         <= INIT;
            raminit_valid <= 1'b1;
            raminit_index <= '0;
          end
        end
        INIT: if (raminit_index == LAST) begin
          // a request landing on the last index is covered by this sweep's ack
          state         <= READY;
          raminit_valid <= 1'b0;
          init_busy     <= 1'b0;
          raminit_index <= '0;
          init_done     <= 1'b1;
          flush_ack     <= pending | flush_req;
          pending       <= 1'b0;
        end else begin
          raminit_index <= raminit_index + 1'b1;
          pending       <= pending | flush_req;
        end
        default: begin
          // unused encoding: restart a full sweep so the tables end up known
          state         <= INIT;
          raminit_valid <= 1'b1;
          init_busy     <= 1'b1;
          raminit_index <= '0;
        end
      endcase
    end
  end
endmodule
